rmw_issue_queue: RTL and testbench

RMW_ISSUE_QUEUE -- requirements
Module: rmw_issue_queue

---
 rtl/rmw_issue_queue.sv | 125 ++++++++++++
 tb/tb_rmw_issue_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_issue_queue.sv
// Issue queue for read-modify-write requests: a circular FIFO of {op, addr}
// entries whose head drives a memory stage, with saturating per-op issue counters.
module rmw_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_req_valid,
    output logic                          io_req_ready,
    input  logic                          io_req_op,
    input  logic [ADDR_W-1:0]             io_req_addr,
    input  logic                          io_flush,
    output logic                          io_out_valid,
    input  logic                          io_out_ready,
    output logic                          io_enable,
    output logic [31:0]                   io_addr,
    output logic [15:0]                   io_inc_count,
    output logic [15:0]                   io_copy_count,
    output logic [$clog2(DEPTH+1)-1:0]    io_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + 1;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [15:0]      inc_count_reg, inc_count_next;
    logic [15:0]      copy_count_reg, copy_count_next;

    logic [ENT_W-1:0] entries [DEPTH];
    logic [ENT_W-1:0] head_entry;
    logic             not_empty;
    logic             not_full;
    logic             enq;
    logic             deq;
    logic             head_op;
    logic [ADDR_W-1:0] head_addr;

    // Entry storage: each slot loads only when the tail points at it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENT_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (enq && (tail_reg == PTR_W'(gi))) begin
                    entry_reg <= {io_req_op, io_req_addr};
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign not_empty  = (count_reg != '0);
    assign not_full   = (count_reg < CNT_W'(DEPTH));
    assign head_entry = entries[head_reg];
    assign head_op    = head_entry[ENT_W-1];
    assign head_addr  = head_entry[ADDR_W-1:0];

    // Handshakes are suppressed while reset is held so nothing moves.
    assign io_req_ready = reset && not_full && !io_flush;
    assign io_out_valid = reset && not_empty && !io_flush;
    assign enq          = io_req_valid && io_req_ready;
    assign deq          = io_out_valid && io_out_ready;

    assign io_enable     = reset && not_empty && head_op;
    assign io_addr       = (reset && not_empty) ? 32'(head_addr) : 32'd0;
    assign io_count      = count_reg;
    assign io_inc_count  = inc_count_reg;
    assign io_copy_count = copy_count_reg;

    always_comb begin
        head_next       = head_reg;
        tail_next       = tail_reg;
        count_next      = count_reg;
        inc_count_next  = inc_count_reg;
        copy_count_next = copy_count_reg;

        if (io_flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (enq) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (deq) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
            if (deq && head_op && (inc_count_reg != 16'hFFFF)) begin
                inc_count_next = inc_count_reg + 16'd1;
            end
            if (deq && !head_op && (copy_count_reg != 16'hFFFF)) begin
                copy_count_next = copy_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            inc_count_reg  <= '0;
            copy_count_reg <= '0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            inc_count_reg  <= inc_count_next;
            copy_count_reg <= copy_count_next;
        end
    end

endmodule

// File: tb/tb_rmw_issue_queue.sv
// Self-checking bench for rmw_issue_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_rmw_issue_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_req_op;
    logic [2:0]  io_req_addr;
    logic        io_flush;
    logic        io_out_valid;
    logic        io_out_ready;
    logic        io_enable;
    logic [31:0] io_addr;
    logic [15:0] io_inc_count;
    logic [15:0] io_copy_count;
    logic [2:0]  io_count;

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;

    // Reference model: pending {op, addr} entries in issue order plus counters.
    logic [3:0] mq[$];
    int         m_inc  = 0;
    int         m_copy = 0;

    always #5 clk = ~clk;

    rmw_issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_op    (io_req_op),
        .io_req_addr  (io_req_addr),
        .io_flush     (io_flush),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_enable    (io_enable),
        .io_addr      (io_addr),
        .io_inc_count (io_inc_count),
        .io_copy_count(io_copy_count),
        .io_count     (io_count)
    );

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        bit         do_enq;
        bit         do_deq;
        logic [3:0] e;
        do_enq = reset && io_req_valid && !io_flush && (mq.size() < DEPTH);
        do_deq = reset && io_out_ready && !io_flush && (mq.size() > 0);
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_inc  = 0;
            m_copy = 0;
        end else if (io_flush) begin
            mq.delete();
            if (verbose) $display("flush");
        end else begin
            if (do_deq) begin
                e = mq.pop_front();
                if (e[3]) begin
                    if (m_inc < 65535) m_inc++;
                end else begin
                    if (m_copy < 65535) m_copy++;
                end
                if (verbose) $display("deq op=%0d addr=%0d", e[3], e[2:0]);
            end
            if (do_enq) begin
                mq.push_back({io_req_op, io_req_addr});
                if (verbose) $display("enq op=%0d addr=%0d", io_req_op, io_req_addr);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; io_req_valid = 1'b1; io_out_ready = 1'b1; io_flush = 1'b0;
        io_req_op = 1'b1; io_req_addr = 3'd2;
        tick();
        tick();
        checks++;
        if (io_out_valid !== 1'b0 || io_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: valid=%0b ready=%0b required 0/0", io_out_valid, io_req_ready);
        end
        checks++;
        if (io_enable !== 1'b0 || io_addr !== 32'd0 || io_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_head: en=%0b addr=%0d count=%0d required 0/0/0", io_enable, io_addr, io_count);
        end
        checks++;
        if (io_inc_count !== 16'd0 || io_copy_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: inc=%0d copy=%0d required 0/0", io_inc_count, io_copy_count);
        end
        reset = 1'b1; io_req_valid = 1'b0; io_out_ready = 1'b0;
        #1;
        checks++;
        if (io_req_ready !== 1'b1 || io_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_exit: ready=%0b count=%0d required 1/0", io_req_ready, io_count);
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] ent [4];
        ent[0] = 4'b1011; ent[1] = 4'b0101; ent[2] = 4'b1111; ent[3] = 4'b1000;
        io_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_req_valid = 1'b1;
            {io_req_op, io_req_addr} = ent[i];
            tick();
        end
        {io_req_op, io_req_addr} = 4'b1110;
        #1;
        checks++;
        if (io_count !== 3'd4 || io_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d ready=%0b required 4/0", io_count, io_req_ready);
        end
        tick();
        io_req_valid = 1'b0;
        checks++;
        if (io_count !== 3'd4 || io_enable !== 1'b1 || io_addr !== 32'd3) begin
            errors++;
            $display("FAIL full_head: count=%0d en=%0b addr=%0d required 4/1/3", io_count, io_enable, io_addr);
        end
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (io_out_valid !== 1'b1 || io_enable !== ent[i][3] || io_addr !== 32'(ent[i][2:0])) begin
                errors++;
                $display("FAIL drain_%0d: valid=%0b en=%0b addr=%0d required 1/%0b/%0d",
                         i, io_out_valid, io_enable, io_addr, ent[i][3], ent[i][2:0]);
            end
            tick();
        end
        io_out_ready = 1'b0;
        #1;
        checks++;
        if (io_out_valid !== 1'b0 || io_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: valid=%0b count=%0d required 0/0", io_out_valid, io_count);
        end
        checks++;
        if (io_inc_count !== 16'd3 || io_copy_count !== 16'd1) begin
            errors++;
            $display("FAIL drain_cnt: inc=%0d copy=%0d required 3/1", io_inc_count, io_copy_count);
        end
    endtask

    task automatic test_simul_wrap();
        io_out_ready = 1'b0;
        io_req_valid = 1'b1;
        {io_req_op, io_req_addr} = 4'b0001;
        tick();
        {io_req_op, io_req_addr} = 4'b1010;
        tick();
        io_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            {io_req_op, io_req_addr} = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (io_count !== 3'd2 || {io_enable, io_addr[2:0]} !== mq[0] || io_addr[31:3] !== 29'd0) begin
                errors++;
                $display("FAIL simul_%0d: count=%0d head=%0b/%0d required 2/%0b/%0d",
                         k, io_count, io_enable, io_addr, mq[0][3], mq[0][2:0]);
            end
            tick();
        end
        io_req_valid = 1'b0;
        checks++;
        if (io_count !== 3'd2) begin
            errors++;
            $display("FAIL simul_hold: count=%0d required 2", io_count);
        end
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            checks++;
            if (io_out_valid !== 1'b1 || {io_enable, io_addr[2:0]} !== mq[0]) begin
                errors++;
                $display("FAIL wrap_drain_%0d: valid=%0b head=%0b/%0d required 1/%0b/%0d",
                         k, io_out_valid, io_enable, io_addr, mq[0][3], mq[0][2:0]);
            end
            tick();
        end
        io_out_ready = 1'b0;
        checks++;
        if (io_count !== 3'd0 || io_inc_count !== 16'(m_inc) || io_copy_count !== 16'(m_copy)) begin
            errors++;
            $display("FAIL wrap_end: count=%0d inc=%0d copy=%0d required 0/%0d/%0d",
                     io_count, io_inc_count, io_copy_count, m_inc, m_copy);
        end
    endtask

    task automatic test_flush();
        int saved_inc;
        int saved_copy;
        io_out_ready = 1'b0;
        io_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            {io_req_op, io_req_addr} = 4'($urandom_range(0, 15));
            tick();
        end
        saved_inc  = m_inc;
        saved_copy = m_copy;
        io_flush = 1'b1; io_out_ready = 1'b1;
        #1;
        checks++;
        if (io_count !== 3'd3 || io_req_ready !== 1'b0 || io_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hs: count=%0d ready=%0b valid=%0b required 3/0/0", io_count, io_req_ready, io_out_valid);
        end
        tick();
        io_flush = 1'b0; io_req_valid = 1'b0; io_out_ready = 1'b0;
        #1;
        checks++;
        if (io_count !== 3'd0 || io_out_valid !== 1'b0 || io_enable !== 1'b0 || io_addr !== 32'd0) begin
            errors++;
            $display("FAIL flush_empty: count=%0d valid=%0b en=%0b addr=%0d required 0/0/0/0",
                     io_count, io_out_valid, io_enable, io_addr);
        end
        checks++;
        if (io_inc_count !== 16'(saved_inc) || io_copy_count !== 16'(saved_copy)) begin
            errors++;
            $display("FAIL flush_cnt: inc=%0d copy=%0d required %0d/%0d", io_inc_count, io_copy_count, saved_inc, saved_copy);
        end
    endtask

    task automatic test_reset_midstream();
        io_out_ready = 1'b0;
        io_req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {io_req_op, io_req_addr} = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0; io_out_ready = 1'b1;
        #1;
        checks++;
        if (io_out_valid !== 1'b0 || io_req_ready !== 1'b0 || io_enable !== 1'b0 || io_addr !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_hold: valid=%0b ready=%0b en=%0b addr=%0d required 0/0/0/0",
                     io_out_valid, io_req_ready, io_enable, io_addr);
        end
        tick();
        reset = 1'b1; io_req_valid = 1'b0; io_out_ready = 1'b0;
        #1;
        checks++;
        if (io_count !== 3'd0 || io_out_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: count=%0d valid=%0b ready=%0b required 0/0/1", io_count, io_out_valid, io_req_ready);
        end
        checks++;
        if (io_inc_count !== 16'd0 || io_copy_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_cnt: inc=%0d copy=%0d required 0/0", io_inc_count, io_copy_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_head;
        for (int c = 0; c < 300; c++) begin
            io_req_valid = 1'($urandom_range(0, 1));
            io_out_ready = 1'($urandom_range(0, 1));
            io_flush     = ($urandom_range(0, 19) == 0);
            {io_req_op, io_req_addr} = 4'($urandom_range(0, 15));
            #1;
            exp_head = (mq.size() > 0) ? mq[0] : 4'd0;
            checks++;
            if (io_req_ready !== ((mq.size() < DEPTH) && !io_flush) ||
                io_out_valid !== ((mq.size() > 0) && !io_flush)) begin
                errors++;
                $display("FAIL rand_hs_%0d: ready=%0b valid=%0b size=%0d flush=%0b",
                         c, io_req_ready, io_out_valid, mq.size(), io_flush);
            end
            checks++;
            if (io_enable !== exp_head[3] || io_addr !== 32'(exp_head[2:0])) begin
                errors++;
                $display("FAIL rand_head_%0d: en=%0b addr=%0d required %0b/%0d",
                         c, io_enable, io_addr, exp_head[3], exp_head[2:0]);
            end
            tick();
            checks++;
            if (io_count !== 3'(mq.size()) || io_inc_count !== 16'(m_inc) || io_copy_count !== 16'(m_copy)) begin
                errors++;
                $display("FAIL rand_state_%0d: count=%0d inc=%0d copy=%0d required %0d/%0d/%0d",
                         c, io_count, io_inc_count, io_copy_count, mq.size(), m_inc, m_copy);
            end
        end
        io_req_valid = 1'b0; io_out_ready = 1'b0; io_flush = 1'b0;
    endtask

    task automatic test_saturation();
        int cycles;
        verbose = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        io_req_valid = 1'b1; io_req_op = 1'b1; io_req_addr = 3'd6; io_out_ready = 1'b1;
        cycles = 0;
        while (m_inc < 65534 && cycles < 70000) begin
            tick();
            cycles++;
        end
        checks++;
        if (io_inc_count !== 16'hFFFE || m_inc != 65534) begin
            errors++;
            $display("FAIL sat_pre: inc=%0h required fffe after %0d cycles", io_inc_count, cycles);
        end
        tick();
        checks++;
        if (io_inc_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: inc=%0h required ffff", io_inc_count);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (io_inc_count !== 16'hFFFF || io_copy_count !== 16'd0 || io_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: inc=%0h copy=%0d valid=%0b required ffff/0/1", io_inc_count, io_copy_count, io_out_valid);
        end
        io_req_valid = 1'b0; io_out_ready = 1'b0;
        verbose = 1'b1;
    endtask

    initial begin
        reset = 1'b0; io_req_valid = 1'b0; io_req_op = 1'b0; io_req_addr = 3'd0;
        io_flush = 1'b0; io_out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_simul_wrap();
        test_flush();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
